// File: rtl/hamming_rx_if.sv
// Frame handshake bundle between the channel, the SEC decoder and the downstream consumer.
// The decoder takes the slave view; the link environment takes the master view.
interface hamming_rx_if;
    logic [0:65] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [0:58] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_err;
    logic        ack;
    logic        nak;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_err, ack, nak
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_err, ack, nak
    );
endinterface

// File: rtl/hamming_rx_decoder.sv
// Receive-side Hamming(66,59) single-error corrector with a two-stage elastic pipeline,
// per-frame ACK/NAK back to the sender and saturating correction/failure counters.
module hamming_rx_decoder #(
    parameter int CNT_W    = 16,
    parameter bit DROP_BAD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    hamming_rx_if.slave      bus,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] bad_cnt
);

    typedef enum logic [1:0] {
        CLS_CLEAN = 2'd0,
        CLS_CORR  = 2'd1,
        CLS_BAD   = 2'd2
    } cls_e;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    function automatic logic [6:0] calc_syndrome(input logic [0:65] cw);
        logic [6:0] s;
        s = 7'd0;
        for (int i = 0; i < 66; i++) begin
            if (cw[7'(i)]) s = s ^ 7'(i + 1);
        end
        return s;
    endfunction

    // Syndromes beyond the codeword length cannot point at a real bit.
    function automatic cls_e classify(input logic [6:0] syn);
        cls_e c;
        if (syn == 7'd0)       c = CLS_CLEAN;
        else if (syn <= 7'd66) c = CLS_CORR;
        else                   c = CLS_BAD;
        return c;
    endfunction

    function automatic logic [0:65] correct(input logic [0:65] cw, input logic [6:0] syn);
        logic [0:65] fixed;
        fixed = cw;
        for (int i = 0; i < 66; i++) begin
            if (syn == 7'(i + 1)) fixed[7'(i)] = ~fixed[7'(i)];
        end
        return fixed;
    endfunction

    // Data bits are the runs between the power-of-two parity positions.
    function automatic logic [0:58] extract_payload(input logic [0:65] cw);
        return {cw[2], cw[4:6], cw[8:14], cw[16:30], cw[32:62], cw[64:65]};
    endfunction

    logic             s1_valid_r;
    logic [0:65]      s1_code_r;
    logic [6:0]       s1_syn_r;
    logic             s2_valid_r;
    logic [0:58]      out_data_r;
    logic             out_err_r;
    logic             ack_r;
    logic             nak_r;
    logic [CNT_W-1:0] corr_cnt_r;
    logic [CNT_W-1:0] bad_cnt_r;

    logic [6:0]       in_syn_s;
    cls_e             in_cls_s;
    cls_e             s1_cls_s;
    logic             adv_s;
    logic             accept_s;
    logic             s1_keep_s;
    logic [0:58]      s1_payload_s;

    // Syndrome of the incoming word, advance condition and stage-1 correction.
    always_comb begin
        in_syn_s     = calc_syndrome(bus.in_data);
        in_cls_s     = classify(in_syn_s);
        adv_s        = !s2_valid_r || bus.out_ready;
        accept_s     = adv_s && bus.in_valid;
        s1_cls_s     = classify(s1_syn_r);
        s1_payload_s = extract_payload(correct(s1_code_r, s1_syn_r));
        // A dropped bad frame never occupies S2, so it cannot stall the pipe.
        s1_keep_s    = s1_valid_r && !(DROP_BAD && (s1_cls_s == CLS_BAD));
    end

    // Two-stage pipeline; both stages freeze together while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_code_r  <= '0;
            s1_syn_r   <= 7'd0;
            s2_valid_r <= 1'b0;
            out_data_r <= '0;
            out_err_r  <= 1'b0;
        end else if (adv_s) begin
            s1_valid_r <= bus.in_valid;
            s1_code_r  <= bus.in_data;
            s1_syn_r   <= in_syn_s;
            s2_valid_r <= s1_keep_s;
            out_err_r  <= s1_keep_s && (s1_cls_s == CLS_BAD);
            if (s1_keep_s) begin
                out_data_r <= s1_payload_s;
            end
        end
    end

    // Verdict pulse and statistics follow the accepting edge, so a stall cannot delay them.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r      <= 1'b0;
            nak_r      <= 1'b0;
            corr_cnt_r <= '0;
            bad_cnt_r  <= '0;
        end else begin
            ack_r <= accept_s && (in_cls_s != CLS_BAD);
            nak_r <= accept_s && (in_cls_s == CLS_BAD);
            if (accept_s && (in_cls_s == CLS_CORR) && (corr_cnt_r != CNT_MAX)) begin
                corr_cnt_r <= corr_cnt_r + CNT_W'(1);
            end
            if (accept_s && (in_cls_s == CLS_BAD) && (bad_cnt_r != CNT_MAX)) begin
                bad_cnt_r <= bad_cnt_r + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = adv_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_err   = out_err_r;
    assign bus.ack       = ack_r;
    assign bus.nak       = nak_r;
    assign corr_cnt      = corr_cnt_r;
    assign bad_cnt       = bad_cnt_r;

endmodule
